// File: rtl/hls_deadlock_reporter_pkg.sv
// Shared types and helpers for the deadlock reporter and other deadlock aggregators.
package hls_deadlock_reporter_pkg;

    localparam int CYC_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COUNT  = 2'd1,
        ST_REPORT = 2'd2,
        ST_HALT   = 2'd3
    } state_t;

    // Ceiling log2, usable in parameter defaults.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/hls_deadlock_prio_enc.sv
// Lowest-set-bit encoder: returns the index of the least significant set bit plus a found flag.
module hls_deadlock_prio_enc
    import hls_deadlock_reporter_pkg::*;
#(
    parameter int NUM_MON = 4,
    parameter int ID_W    = (NUM_MON > 1) ? clog2(NUM_MON) : 1
) (
    input  logic [NUM_MON-1:0] i_vec,
    output logic [ID_W-1:0]    o_id,
    output logic               o_found
);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        o_id    = '0;
        o_found = 1'b0;
        // Scan high to low so the lowest set bit is the last one written.
        for (int i = NUM_MON - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_id    = ID_W'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hls_deadlock_reporter.sv
// Deadlock reporter: declares deadlock after THRESH consecutive blocked cycles and emits one report.
module hls_deadlock_reporter
    import hls_deadlock_reporter_pkg::*;
#(
    parameter int NUM_MON = 4,
    parameter int THRESH  = 1024,
    parameter int CNT_W   = 16,
    parameter int ID_W    = (NUM_MON > 1) ? clog2(NUM_MON) : 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic [NUM_MON-1:0] mon_block,
    input  logic               clear,
    output logic               deadlock,
    output logic               rpt_valid,
    input  logic               rpt_ready,
    output logic [ID_W-1:0]    rpt_id,
    output logic [NUM_MON-1:0] rpt_mask,
    output logic [CYC_W-1:0]   rpt_cycle
);

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [CYC_W-1:0]   r_cycle;
    logic               r_deadlock;
    logic               r_valid;
    logic [ID_W-1:0]    r_id;
    logic [NUM_MON-1:0] r_mask;
    logic [CYC_W-1:0]   r_rpt_cycle;

    logic [ID_W-1:0]    w_low_id;
    logic               w_any_block;
    logic               w_declare;
    logic               w_accept;

    // The found flag doubles as the OR-reduction of all block inputs.
    hls_deadlock_prio_enc #(
        .NUM_MON (NUM_MON),
        .ID_W    (ID_W)
    ) u_prio_enc (
        .i_vec   (mon_block),
        .o_id    (w_low_id),
        .o_found (w_any_block)
    );

    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        w_declare    = 1'b0;
        w_accept     = 1'b0;
        if (clear) begin
            w_next_state = ST_IDLE;
            w_cnt_next   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (enable && w_any_block) begin
                        w_next_state = ST_COUNT;
                        w_cnt_next   = CNT_W'(1);
                    end else begin
                        w_cnt_next   = '0;
                    end
                end
                ST_COUNT: begin
                    if (!enable || !w_any_block) begin
                        w_next_state = ST_IDLE;
                        w_cnt_next   = '0;
                    end else if (r_cnt == CNT_W'(THRESH - 1)) begin
                        w_next_state = ST_REPORT;
                        w_cnt_next   = '0;
                        w_declare    = 1'b1;
                    end else begin
                        w_cnt_next   = r_cnt + 1'b1;
                    end
                end
                ST_REPORT: begin
                    if (rpt_ready) begin
                        w_next_state = ST_HALT;
                        w_accept     = 1'b1;
                    end
                end
                ST_HALT: begin
                    w_next_state = ST_HALT;
                end
                default: begin
                    w_next_state = ST_IDLE;
                    w_cnt_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_cycle <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
            r_cycle <= r_cycle + 1'b1;
        end
    end

    // Sticky flag and handshake; clear abandons any pending report.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_deadlock <= 1'b0;
            r_valid    <= 1'b0;
        end else if (clear) begin
            r_deadlock <= 1'b0;
            r_valid    <= 1'b0;
        end else if (w_declare) begin
            r_deadlock <= 1'b1;
            r_valid    <= 1'b1;
        end else if (w_accept) begin
            r_valid    <= 1'b0;
        end
    end

    // Payload is captured once at declaration and held until the next declaration.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_id        <= '0;
            r_mask      <= '0;
            r_rpt_cycle <= '0;
        end else if (w_declare && !clear) begin
            r_id        <= w_low_id;
            r_mask      <= mon_block;
            r_rpt_cycle <= r_cycle;
        end
    end

    assign deadlock  = r_deadlock;
    assign rpt_valid = r_valid;
    assign rpt_id    = r_id;
    assign rpt_mask  = r_mask;
    assign rpt_cycle = r_rpt_cycle;

endmodule

// File: tb/tb_hls_deadlock_reporter.sv
// Directed self-checking bench for hls_deadlock_reporter with NUM_MON=4, THRESH=8.
module tb_hls_deadlock_reporter;

    localparam int NUM_MON = 4;
    localparam int THRESH  = 8;

    logic        clock;
    logic        reset;
    logic        enable;
    logic [3:0]  mon_block;
    logic        clear;
    logic        deadlock;
    logic        rpt_valid;
    logic        rpt_ready;
    logic [1:0]  rpt_id;
    logic [3:0]  rpt_mask;
    logic [31:0] rpt_cycle;

    int          n_checks;
    int          n_errors;
    logic [31:0] edge_cnt;
    logic [31:0] exp_cycle;

    hls_deadlock_reporter #(
        .NUM_MON (NUM_MON),
        .THRESH  (THRESH),
        .CNT_W   (16)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .mon_block (mon_block),
        .clear     (clear),
        .deadlock  (deadlock),
        .rpt_valid (rpt_valid),
        .rpt_ready (rpt_ready),
        .rpt_id    (rpt_id),
        .rpt_mask  (rpt_mask),
        .rpt_cycle (rpt_cycle)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference cycle count: edges seen since reset was released.
    always @(posedge clock or posedge reset) begin
        if (reset) edge_cnt <= '0;
        else       edge_cnt <= edge_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check_report(input string tag, input logic [1:0] id, input logic [3:0] mask,
                                input logic [31:0] cyc);
        check({tag, "_valid"}, 32'(rpt_valid), 32'd1);
        check({tag, "_deadlock"}, 32'(deadlock), 32'd1);
        check({tag, "_id"}, 32'(rpt_id), 32'(id));
        check({tag, "_mask"}, 32'(rpt_mask), 32'(mask));
        check({tag, "_cycle"}, rpt_cycle, cyc);
    endtask

    task automatic accept_and_clear();
        rpt_ready = 1'b1;
        step(1);
        rpt_ready = 1'b0;
        clear     = 1'b1;
        step(1);
        clear     = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        enable    = 1'b0;
        mon_block = '0;
        clear     = 1'b0;
        rpt_ready = 1'b0;

        #12;
        check("rst_deadlock", 32'(deadlock), 32'd0);
        check("rst_valid", 32'(rpt_valid), 32'd0);
        check("rst_payload", {rpt_cycle[23:0], 2'b0, rpt_id, rpt_mask}, 32'd0);
        reset = 1'b0;
        step(2);

        // Persistence: THRESH consecutive samples declare deadlock.
        enable    = 1'b1;
        mon_block = 4'b0100;
        step(THRESH - 1);
        check("persist_early_valid", 32'(rpt_valid), 32'd0);
        check("persist_early_dl", 32'(deadlock), 32'd0);
        step(1);
        exp_cycle = edge_cnt - 1;
        check_report("persist", 2'd2, 4'b0100, exp_cycle);
        step(3);
        check("persist_hold_valid", 32'(rpt_valid), 32'd1);
        rpt_ready = 1'b1;
        step(1);
        rpt_ready = 1'b0;
        check("persist_acc_valid", 32'(rpt_valid), 32'd0);
        check("persist_acc_dl", 32'(deadlock), 32'd1);
        // HALT ignores enable and mon_block.
        enable    = 1'b0;
        mon_block = 4'b0000;
        step(3);
        check("halt_dl_sticky", 32'(deadlock), 32'd1);
        check("halt_no_valid", 32'(rpt_valid), 32'd0);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        check("clear_dl", 32'(deadlock), 32'd0);

        // Glitch rejection: a one-cycle gap restarts the count.
        enable    = 1'b1;
        mon_block = 4'b0001;
        step(THRESH - 1);
        mon_block = 4'b0000;
        step(1);
        mon_block = 4'b0001;
        step(THRESH - 1);
        check("glitch_valid", 32'(rpt_valid), 32'd0);
        check("glitch_dl", 32'(deadlock), 32'd0);
        step(1);
        exp_cycle = edge_cnt - 1;
        check_report("glitch_restart", 2'd0, 4'b0001, exp_cycle);
        accept_and_clear();
        mon_block = 4'b0000;
        step(1);

        // Multiple blockers: lowest index reported, payload stable while stalled.
        mon_block = 4'b1010;
        step(THRESH);
        exp_cycle = edge_cnt - 1;
        check_report("multi", 2'd1, 4'b1010, exp_cycle);
        mon_block = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            step(1);
            check_report("multi_stall", 2'd1, 4'b1010, exp_cycle);
        end
        accept_and_clear();
        mon_block = 4'b0000;
        step(1);

        // Clear during REPORT abandons the report; a new block yields a fresh one.
        mon_block = 4'b0011;
        step(THRESH);
        exp_cycle = edge_cnt - 1;
        check_report("pre_clear", 2'd0, 4'b0011, exp_cycle);
        clear = 1'b1;
        step(1);
        clear     = 1'b0;
        mon_block = 4'b1000;
        check("clear_rep_valid", 32'(rpt_valid), 32'd0);
        check("clear_rep_dl", 32'(deadlock), 32'd0);
        step(THRESH - 1);
        check("fresh_early_valid", 32'(rpt_valid), 32'd0);
        step(1);
        exp_cycle = edge_cnt - 1;
        check_report("fresh", 2'd3, 4'b1000, exp_cycle);
        accept_and_clear();
        mon_block = 4'b0000;
        step(1);

        // Enable gating: dropping enable mid-count returns to IDLE.
        mon_block = 4'b0010;
        step(5);
        enable = 1'b0;
        step(1);
        enable = 1'b1;
        step(THRESH - 1);
        check("gate_valid", 32'(rpt_valid), 32'd0);
        check("gate_dl", 32'(deadlock), 32'd0);
        step(1);
        exp_cycle = edge_cnt - 1;
        check_report("gate_restart", 2'd1, 4'b0010, exp_cycle);
        accept_and_clear();

        // Async reset mid-COUNT.
        mon_block = 4'b0100;
        step(3);
        #2 reset = 1'b1;
        #1;
        check("rst_count_dl", 32'(deadlock), 32'd0);
        check("rst_count_cycle", dut.r_cycle, 32'd0);
        #2 reset = 1'b0;

        // Async reset mid-REPORT.
        step(THRESH);
        check_report("pre_rst", 2'd2, 4'b0100, 32'd7);
        #2 reset = 1'b1;
        #1;
        check("rst_rep_valid", 32'(rpt_valid), 32'd0);
        check("rst_rep_dl", 32'(deadlock), 32'd0);
        check("rst_rep_id_mask", {26'd0, rpt_id, rpt_mask}, 32'd0);
        check("rst_rep_cycle", rpt_cycle, 32'd0);
        mon_block = 4'b0000;
        #2 reset = 1'b0;
        step(1);
        check("cycle_restart", dut.r_cycle, 32'd1);

        // Cycle counter wrap from a preloaded value.
        @(negedge clock);
        force dut.r_cycle = 32'hFFFF_FFFE;
        #1 release dut.r_cycle;
        step(1);
        check("cycle_pre_wrap", dut.r_cycle, 32'hFFFF_FFFF);
        step(1);
        check("cycle_wrap", dut.r_cycle, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
